shift_add_mult_ctrl: RTL and testbench

Sequential N×N unsigned multiplier controller that time-shares a single N-bit carry look-ahead adder (claBlock) across N shift-add iterations. It accepts operands on a start pulse, runs one partial-product add-and-shift per clock, and presents a 2N-bit product with a one-cycle done strobe. It sits between the operand source and the product consumer as the low-area alternative to the fully parallel array multiplier.

---
 rtl/shift_add_mult_ctrl.sv | 165 ++++++++++++++++
 tb/tb_shift_add_mult_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mult_ctrl.sv
// Purpose: sequential NxN unsigned shift-add multiplier sharing one N-bit carry look-ahead adder.
// Latency: N+1 edges from accepted start to the done strobe; one result per N+1 cycles back-to-back.
// Backpressure: ready is low while iterating; start is ignored until ready returns (IDLE or DONE).
//
// Ports:
//   clk, resetN          rising-edge clock, asynchronous active-low reset
//   start, a, b          operand strobe and operands, sampled only when ready=1
//   ready, busy          state decodes: can accept start / iteration in progress
//   done, product        one-cycle completion strobe and registered 2N-bit product

// N-bit carry look-ahead adder: each carry is a flat sum of generate/propagate products
// rather than a chained ripple, so every carry is two logic levels deep after g/p.
module claBlock #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cIn,
    output logic [W-1:0] sum,
    output logic         cOut
);
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   carry;
    logic         accTerm;
    logic         propRun;

    assign g = x & y;
    assign p = x ^ y;

    always_comb begin
        carry   = '0;
        accTerm = 1'b0;
        propRun = 1'b0;
        carry[0] = cIn;
        for (int i = 0; i < W; i++) begin
            // c[i+1] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... | p[i..0]cIn
            accTerm = g[i];
            propRun = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                accTerm = accTerm | (propRun & g[j]);
                propRun = propRun & p[j];
            end
            carry[i+1] = accTerm | (propRun & cIn);
        end
    end

    assign sum  = p ^ carry[W-1:0];
    assign cOut = carry[W];
endmodule

module shift_add_mult_ctrl #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           resetN,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    state_t          stateNext;
    logic [N-1:0]    mcand;
    logic [N-1:0]    accHi;
    logic [N-1:0]    accLo;
    logic [CW-1:0]   count;
    logic [N-1:0]    addend;
    logic [N-1:0]    sumHi;
    logic            cOut;
    logic [2*N-1:0]  shifted;
    logic            load;
    logic            finish;

    // Multiplier bit in accLo[0] selects whether this iteration adds the multiplicand.
    assign addend = accLo[0] ? mcand : '0;

    claBlock #(.W(N)) uCla (
        .x    (accHi),
        .y    (addend),
        .cIn  (1'b0),
        .sum  (sumHi),
        .cOut (cOut)
    );

    // The adder carry becomes the new top bit; dropping it corrupts products once
    // accHi + mcand overflows N bits.
    assign shifted = {cOut, sumHi, accLo[N-1:1]};

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        ready     = 1'b0;
        busy      = 1'b0;
        load      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    load      = 1'b1;
                    stateNext = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (count == LAST) begin
                    finish    = 1'b1;
                    stateNext = DONE;
                end
            end
            DONE: begin
                ready = 1'b1;
                if (start) begin
                    load      = 1'b1;
                    stateNext = RUN;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            mcand   <= '0;
            accHi   <= '0;
            accLo   <= '0;
            count   <= '0;
            product <= '0;
            done    <= 1'b0;
        end else begin
            done <= finish;
            if (load) begin
                mcand <= a;
                accHi <= '0;
                accLo <= b;
                count <= '0;
            end else if (busy) begin
                {accHi, accLo} <= shifted;
                count          <= count + CW'(1);
                // Only the final shifted value is published; partial sums stay internal.
                if (finish) begin
                    product <= shifted;
                end
            end
        end
    end
endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
module tb_shift_add_mult_ctrl;
    logic        clk;
    logic        resetN;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] product;

    logic        start4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic        ready4;
    logic        busy4;
    logic        done4;
    logic [7:0]  product4;

    int tests = 0;
    int fails = 0;
    int doneCnt4 = 0;
    int accept4 = 0;
    int cyc;
    int bcyc;
    int doneSeen;

    shift_add_mult_ctrl #(.N(8)) dut (
        .clk(clk), .resetN(resetN), .start(start), .a(a), .b(b),
        .ready(ready), .busy(busy), .done(done), .product(product)
    );

    shift_add_mult_ctrl #(.N(4)) dut4 (
        .clk(clk), .resetN(resetN), .start(start4), .a(a4), .b(b4),
        .ready(ready4), .busy(busy4), .done(done4), .product(product4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done4) doneCnt4 <= doneCnt4 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called on the negedge where start was driven; returns at the negedge where
    // done is seen (or after a 30-cycle bound). Optionally re-drives start/a/b at cycle pokeAt.
    task automatic waitDone(input logic holdStart, input int pokeAt, input logic [7:0] pa,
                            input logic [7:0] pb, output int cycles, output int busyCycles);
        cycles = 0;
        busyCycles = 0;
        while (cycles < 30) begin
            @(negedge clk);
            cycles++;
            if (cycles == 1 && !holdStart) start = 1'b0;
            if (cycles == pokeAt) begin
                start = 1'b1;
                a = pa;
                b = pb;
            end
            if (cycles == pokeAt + 1 && !holdStart) start = 1'b0;
            if (busy) busyCycles++;
            if (done) break;
        end
    endtask

    task automatic runOp(input logic [7:0] ta, input logic [7:0] tb2, input logic [15:0] exp,
                         input string tag);
        int c;
        int bc;
        start = 1'b1;
        a = ta;
        b = tb2;
        waitDone(1'b0, -5, 8'd0, 8'd0, c, bc);
        check({tag, " latency"}, c, 9);
        check({tag, " busy cycles"}, bc, 8);
        check({tag, " product"}, product, exp);
        check({tag, " ready with done"}, ready, 1);
        @(negedge clk);
        check({tag, " done single"}, done, 0);
        check({tag, " product held"}, product, exp);
        check({tag, " back to idle"}, {ready, busy}, 2'b10);
    endtask

    initial begin
        resetN = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        start4 = 1'b0;
        a4 = '0;
        b4 = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset ready", ready, 1);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset product", product, 0);
        resetN = 1'b1;
        @(negedge clk);

        runOp(8'd13, 8'd11, 16'd143, "13x11");
        runOp(8'd255, 8'd255, 16'hFE01, "255x255");
        runOp(8'd0, 8'd200, 16'd0, "0x200");
        runOp(8'd200, 8'd0, 16'd0, "200x0");
        runOp(8'd129, 8'd254, 16'd32766, "129x254");

        // Start pulse with new operands mid-RUN must be ignored.
        start = 1'b1;
        a = 8'd50;
        b = 8'd3;
        waitDone(1'b0, 3, 8'd9, 8'd9, cyc, bcyc);
        check("ignore-in-run latency", cyc, 9);
        check("ignore-in-run product", product, 150);
        @(negedge clk);
        check("ignore-in-run no extra op", {ready, busy, done}, 3'b100);

        // Start held high: second operands accepted only at DONE.
        start = 1'b1;
        a = 8'd7;
        b = 8'd9;
        waitDone(1'b1, 2, 8'd3, 8'd5, cyc, bcyc);
        check("b2b first latency", cyc, 9);
        check("b2b first busy", bcyc, 8);
        check("b2b first product", product, 63);
        check("b2b ready in done", ready, 1);
        waitDone(1'b0, -5, 8'd0, 8'd0, cyc, bcyc);
        check("b2b second latency", cyc, 9);
        check("b2b second busy", bcyc, 8);
        check("b2b second product", product, 15);
        @(negedge clk);

        // Reset mid-RUN abandons the operation.
        start = 1'b1;
        a = 8'd100;
        b = 8'd100;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre-reset busy", busy, 1);
        resetN = 1'b0;
        #1;
        check("mid-run reset product", product, 0);
        check("mid-run reset done", done, 0);
        check("mid-run reset busy", busy, 0);
        check("mid-run reset ready", ready, 1);
        @(negedge clk);
        resetN = 1'b1;
        doneSeen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        check("abandoned op no done", doneSeen, 0);
        runOp(8'd100, 8'd100, 16'd10000, "100x100 after reset");

        // N=4 exhaustive sweep.
        doneCnt4 = 0;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                logic [7:0] ref4;
                int k;
                ref4 = 8'(i * j);
                start4 = 1'b1;
                a4 = 4'(i);
                b4 = 4'(j);
                accept4++;
                k = 0;
                while (k < 12) begin
                    @(negedge clk);
                    k++;
                    if (k == 1) start4 = 1'b0;
                    if (done4) break;
                end
                check($sformatf("n4 %0dx%0d", i, j), product4, ref4);
            end
        end
        @(negedge clk);
        check("n4 done count", doneCnt4, accept4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
